// File: rtl/wb_pkg.sv
// Shared encodings and the MEM->WB payload layout for the writeback stage.
package wb_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] LT_LW   = 3'b000;
  localparam logic [2:0] LT_LB   = 3'b001;
  localparam logic [2:0] LT_LBU  = 3'b010;
  localparam logic [2:0] LT_LH   = 3'b011;
  localparam logic [2:0] LT_LHU  = 3'b100;
  localparam logic [2:0] LT_LWL  = 3'b101;
  localparam logic [2:0] LT_LWR  = 3'b110;
  localparam logic [2:0] LT_RSVD = 3'b111;

  localparam logic [1:0] HILO_NONE = 2'b00;
  localparam logic [1:0] HILO_MD   = 2'b01;
  localparam logic [1:0] HILO_MTHI = 2'b10;
  localparam logic [1:0] HILO_MTLO = 2'b11;

  // Everything captured from the memory stage except the (parameter-width) destination.
  typedef struct packed {
    logic              reg_en;
    logic              mem_read;
    logic [2:0]        load_type;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] rt_data;
    logic [1:0]        hilo_op;
    logic [2*DATA_W-1:0] md_result;
    logic              excp;
  } wb_payload_t;

endpackage

// File: rtl/wb_load_align.sv
// Load data alignment: extracts/extends the addressed bytes and builds LWL/LWR results and strobes.
module wb_load_align
  import wb_pkg::*;
#(
  parameter bit MERGE_MODE = 1'b1
) (
  input  logic [2:0]        load_type,
  input  logic [1:0]        a,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] data,
  output logic [3:0]        wstrb
);

  logic [DATA_W-1:0] fill;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  always_comb begin
    fill     = MERGE_MODE ? rt_data : 32'h0;
    byte_sel = mem_rdata[7:0];
    case (a)
      2'd0: byte_sel = mem_rdata[7:0];
      2'd1: byte_sel = mem_rdata[15:8];
      2'd2: byte_sel = mem_rdata[23:16];
      2'd3: byte_sel = mem_rdata[31:24];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = a[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    data     = mem_rdata;
    wstrb    = 4'hF;

    case (load_type)
      LT_LW:  data = mem_rdata;
      LT_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU: data = {24'h0, byte_sel};
      // Odd halfword addresses fault upstream; write zero rather than a torn half.
      LT_LH:  data = a[0] ? 32'h0 : {{16{half_sel[15]}}, half_sel};
      LT_LHU: data = a[0] ? 32'h0 : {16'h0, half_sel};
      LT_LWL: begin
        case (a)
          2'd0: begin data = {mem_rdata[7:0],  fill[23:0]}; wstrb = 4'b1000; end
          2'd1: begin data = {mem_rdata[15:0], fill[15:0]}; wstrb = 4'b1100; end
          2'd2: begin data = {mem_rdata[23:0], fill[7:0]};  wstrb = 4'b1110; end
          default: begin data = mem_rdata; wstrb = 4'b1111; end
        endcase
      end
      LT_LWR: begin
        case (a)
          2'd0: begin data = mem_rdata;                          wstrb = 4'b1111; end
          2'd1: begin data = {fill[31:24], mem_rdata[31:8]};     wstrb = 4'b0111; end
          2'd2: begin data = {fill[31:16], mem_rdata[31:16]};    wstrb = 4'b0011; end
          default: begin data = {fill[31:8], mem_rdata[31:24]};  wstrb = 4'b0001; end
        endcase
      end
      default: begin
        data  = 32'h0;
        wstrb = 4'h0;
      end
    endcase

    // Merged writes always cover the whole word; only the reserved encoding stays dark.
    if (MERGE_MODE && load_type != LT_RSVD) wstrb = 4'hF;
  end

endmodule

// File: rtl/wb_pipe_stage.sv
// MIPS writeback stage: MEM->WB register, load alignment, GPR write port, HI/LO and retire counter.
module wb_pipe_stage
  import wb_pkg::*;
#(
  parameter int unsigned REG_AW     = 6,
  parameter bit          MERGE_MODE = 1'b1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ms_valid,
  output logic                ws_allowin,
  input  logic                ms_reg_en,
  input  logic [REG_AW-1:0]   ms_reg_waddr,
  input  logic                ms_mem_read,
  input  logic [2:0]          ms_load_type,
  input  logic [DATA_W-1:0]   ms_alu_result,
  input  logic [DATA_W-1:0]   ms_mem_rdata,
  input  logic [DATA_W-1:0]   ms_rt_data,
  input  logic [1:0]          ms_hilo_op,
  input  logic [2*DATA_W-1:0] ms_md_result,
  input  logic                ms_excp,
  input  logic                wb_stall,
  output logic                ws_valid,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [3:0]          rf_wstrb,
  output logic [DATA_W-1:0]   hi,
  output logic [DATA_W-1:0]   lo,
  output logic [CNT_W-1:0]    retire_cnt
);

  wb_payload_t       ws_q;
  logic [REG_AW-1:0] waddr_q;
  logic              ready_go;
  logic              commit;
  logic [DATA_W-1:0] align_data;
  logic [3:0]        align_wstrb;

  assign ready_go   = ~wb_stall;
  assign ws_allowin = ~ws_valid | ready_go;
  assign commit     = ws_valid & ready_go & ~ws_q.excp;

  // MEM->WB pipeline register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid <= 1'b0;
      ws_q     <= '0;
      waddr_q  <= '0;
    end else if (ws_allowin) begin
      ws_valid <= ms_valid;
      if (ms_valid) begin
        waddr_q           <= ms_reg_waddr;
        ws_q.reg_en       <= ms_reg_en;
        ws_q.mem_read     <= ms_mem_read;
        ws_q.load_type    <= ms_load_type;
        ws_q.alu_result   <= ms_alu_result;
        ws_q.mem_rdata    <= ms_mem_rdata;
        ws_q.rt_data      <= ms_rt_data;
        ws_q.hilo_op      <= ms_hilo_op;
        ws_q.md_result    <= ms_md_result;
        ws_q.excp         <= ms_excp;
      end
    end
  end

  // Architectural HI/LO and retire count move only on a committing slot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi         <= '0;
      lo         <= '0;
      retire_cnt <= '0;
    end else if (commit) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
      case (ws_q.hilo_op)
        HILO_MD: begin
          hi <= ws_q.md_result[2*DATA_W-1:DATA_W];
          lo <= ws_q.md_result[DATA_W-1:0];
        end
        HILO_MTHI: hi <= ws_q.alu_result;
        HILO_MTLO: lo <= ws_q.alu_result;
        default: ;
      endcase
    end
  end

  wb_load_align #(
    .MERGE_MODE(MERGE_MODE)
  ) u_align (
    .load_type (ws_q.load_type),
    .a         (ws_q.alu_result[1:0]),
    .mem_rdata (ws_q.mem_rdata),
    .rt_data   (ws_q.rt_data),
    .data      (align_data),
    .wstrb     (align_wstrb)
  );

  // GPR write port is a single-cycle commit pulse; strobes are dark whenever no write happens.
  assign rf_we    = commit & ws_q.reg_en;
  assign rf_waddr = waddr_q;
  assign rf_wdata = ws_q.mem_read ? align_data : ws_q.alu_result;
  assign rf_wstrb = !rf_we ? 4'h0 : (ws_q.mem_read ? align_wstrb : 4'hF);

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Scoreboard bench for wb_pipe_stage: a merge-mode and a strobe-mode (4-bit counter) instance share stimulus.
module tb_wb_pipe_stage;
  import wb_pkg::*;

  localparam int unsigned REG_AW = 6;

  logic        clk;
  logic        resetn;
  logic        ms_valid, ms_reg_en, ms_mem_read, ms_excp, wb_stall;
  logic [REG_AW-1:0] ms_reg_waddr;
  logic [2:0]  ms_load_type;
  logic [31:0] ms_alu_result, ms_mem_rdata, ms_rt_data;
  logic [1:0]  ms_hilo_op;
  logic [63:0] ms_md_result;

  logic              mg_ws_allowin, mg_ws_valid, mg_rf_we;
  logic [REG_AW-1:0] mg_rf_waddr;
  logic [31:0]       mg_rf_wdata, mg_hi, mg_lo, mg_retire_cnt;
  logic [3:0]        mg_rf_wstrb;
  logic              sb_ws_allowin, sb_ws_valid, sb_rf_we;
  logic [REG_AW-1:0] sb_rf_waddr;
  logic [31:0]       sb_rf_wdata, sb_hi, sb_lo;
  logic [3:0]        sb_rf_wstrb, sb_retire_cnt;

  wb_pipe_stage #(.REG_AW(REG_AW), .MERGE_MODE(1'b1), .CNT_W(32)) dut (
    .clk(clk), .resetn(resetn), .ms_valid(ms_valid), .ws_allowin(mg_ws_allowin),
    .ms_reg_en(ms_reg_en), .ms_reg_waddr(ms_reg_waddr), .ms_mem_read(ms_mem_read),
    .ms_load_type(ms_load_type), .ms_alu_result(ms_alu_result), .ms_mem_rdata(ms_mem_rdata),
    .ms_rt_data(ms_rt_data), .ms_hilo_op(ms_hilo_op), .ms_md_result(ms_md_result),
    .ms_excp(ms_excp), .wb_stall(wb_stall), .ws_valid(mg_ws_valid), .rf_we(mg_rf_we),
    .rf_waddr(mg_rf_waddr), .rf_wdata(mg_rf_wdata), .rf_wstrb(mg_rf_wstrb),
    .hi(mg_hi), .lo(mg_lo), .retire_cnt(mg_retire_cnt)
  );

  wb_pipe_stage #(.REG_AW(REG_AW), .MERGE_MODE(1'b0), .CNT_W(4)) dut_sb (
    .clk(clk), .resetn(resetn), .ms_valid(ms_valid), .ws_allowin(sb_ws_allowin),
    .ms_reg_en(ms_reg_en), .ms_reg_waddr(ms_reg_waddr), .ms_mem_read(ms_mem_read),
    .ms_load_type(ms_load_type), .ms_alu_result(ms_alu_result), .ms_mem_rdata(ms_mem_rdata),
    .ms_rt_data(ms_rt_data), .ms_hilo_op(ms_hilo_op), .ms_md_result(ms_md_result),
    .ms_excp(ms_excp), .wb_stall(wb_stall), .ws_valid(sb_ws_valid), .rf_we(sb_rf_we),
    .rf_waddr(sb_rf_waddr), .rf_wdata(sb_rf_wdata), .rf_wstrb(sb_rf_wstrb),
    .hi(sb_hi), .lo(sb_lo), .retire_cnt(sb_retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [REG_AW-1:0] waddr;
    logic [31:0] wd_m;
    logic [3:0]  ws_m;
    logic [31:0] wd_s;
    logic [3:0]  ws_s;
  } exp_t;

  typedef struct {
    bit          excp;
    bit          reg_en;
    logic [1:0]  hilo_op;
    logic [31:0] alu;
    logic [63:0] md;
  } held_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  held_t       m_h;
  bit          m_occ;
  logic [31:0] m_hi, m_lo;
  int unsigned m_cnt;
  int unsigned vectors;
  int unsigned miscompares;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference write value from the architectural byte-placement rules.
  function automatic void ref_wb(input logic mem_read, input logic [2:0] lt, input logic [31:0] alu,
                                 input logic [31:0] m, input logic [31:0] rt, input bit merge,
                                 output logic [31:0] d, output logic [3:0] st);
    int unsigned a;
    int unsigned k;
    logic [31:0] fill, sh;
    logic [3:0]  ones;
    a    = int'(alu[1:0]);
    k    = 3 - a;
    fill = merge ? rt : 32'h0;
    sh   = m >> (8 * a);
    ones = 4'hF;
    d    = alu;
    st   = 4'hF;
    if (mem_read) begin
      case (lt)
        LT_LW:  d = m;
        LT_LB:  d = {{24{sh[7]}}, sh[7:0]};
        LT_LBU: d = {24'h0, sh[7:0]};
        LT_LH:  d = (a % 2 != 0) ? 32'h0 : {{16{sh[15]}}, sh[15:0]};
        LT_LHU: d = (a % 2 != 0) ? 32'h0 : {16'h0, sh[15:0]};
        LT_LWL: begin
          d  = (m << (8 * k)) | (fill & ((32'h1 << (8 * k)) - 32'h1));
          st = merge ? 4'hF : (ones << k);
        end
        LT_LWR: begin
          d  = (m >> (8 * a)) | (fill & ~(32'hFFFF_FFFF >> (8 * a)));
          st = merge ? 4'hF : (ones >> a);
        end
        default: begin
          d  = 32'h0;
          st = 4'h0;
        end
      endcase
    end
  endfunction

  task automatic model_clear();
    m_occ = 1'b0;
    m_h   = '{default: '0};
    m_hi  = '0;
    m_lo  = '0;
    m_cnt = 0;
    exp_q.delete();
  endtask

  // Model of one clock edge: retire the held slot, then maybe accept a new one.
  task automatic model_edge();
    exp_t e;
    if (m_occ && !wb_stall && !m_h.excp) begin
      case (m_h.hilo_op)
        2'b01: begin m_hi = m_h.md[63:32]; m_lo = m_h.md[31:0]; end
        2'b10: m_hi = m_h.alu;
        2'b11: m_lo = m_h.alu;
        default: ;
      endcase
      m_cnt++;
    end
    if (!m_occ || !wb_stall) begin
      m_occ = ms_valid;
      if (ms_valid) begin
        m_h = '{excp: ms_excp, reg_en: ms_reg_en, hilo_op: ms_hilo_op, alu: ms_alu_result, md: ms_md_result};
        if (!ms_excp && ms_reg_en) begin
          e.waddr = ms_reg_waddr;
          ref_wb(ms_mem_read, ms_load_type, ms_alu_result, ms_mem_rdata, ms_rt_data, 1'b1, e.wd_m, e.ws_m);
          ref_wb(ms_mem_read, ms_load_type, ms_alu_result, ms_mem_rdata, ms_rt_data, 1'b0, e.wd_s, e.ws_s);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    ms_valid = 1'b0;
    wb_stall = 1'b0;
  endtask

  task automatic drive(input bit v, input bit ren, input logic [REG_AW-1:0] wa, input bit mr,
                       input logic [2:0] lt, input logic [31:0] alu, input logic [31:0] rd,
                       input logic [31:0] rt, input logic [1:0] hop, input logic [63:0] md, input bit ex);
    ms_valid = v; ms_reg_en = ren; ms_reg_waddr = wa; ms_mem_read = mr; ms_load_type = lt;
    ms_alu_result = alu; ms_mem_rdata = rd; ms_rt_data = rt; ms_hilo_op = hop;
    ms_md_result = md; ms_excp = ex; wb_stall = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    set_idle();
    model_clear();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ws_valid"}, mg_ws_valid, 0);
    chk({tag, "_rf_we"}, mg_rf_we, 0);
    chk({tag, "_rf_waddr"}, mg_rf_waddr, 0);
    chk({tag, "_rf_wdata"}, mg_rf_wdata, 0);
    chk({tag, "_rf_wstrb"}, mg_rf_wstrb, 0);
    chk({tag, "_hi"}, mg_hi, 0);
    chk({tag, "_lo"}, mg_lo, 0);
    chk({tag, "_cnt"}, mg_retire_cnt, 0);
    chk({tag, "_sb_cnt"}, sb_retire_cnt, 0);
    chk({tag, "_sb_ws_valid"}, sb_ws_valid, 0);
  endtask

  // Monitor: per-cycle architectural state plus scoreboard pop on every GPR write.
  always @(negedge clk) begin
    if (resetn) begin
      chk("ws_valid", mg_ws_valid, m_occ);
      chk("sb_ws_valid", sb_ws_valid, m_occ);
      chk("ws_allowin", mg_ws_allowin, !m_occ || !wb_stall);
      chk("sb_ws_allowin", sb_ws_allowin, !m_occ || !wb_stall);
      chk("rf_we", mg_rf_we, m_occ && !wb_stall && !m_h.excp && m_h.reg_en);
      chk("sb_rf_we", sb_rf_we, m_occ && !wb_stall && !m_h.excp && m_h.reg_en);
      chk("hi", mg_hi, m_hi);
      chk("lo", mg_lo, m_lo);
      chk("sb_hi", sb_hi, m_hi);
      chk("sb_lo", sb_lo, m_lo);
      chk("retire_cnt", mg_retire_cnt, m_cnt);
      chk("sb_retire_cnt", sb_retire_cnt, 4'(m_cnt));
      if (mg_rf_we) begin
        if (exp_q.size() == 0) begin
          chk("rf_we_without_expected", mg_rf_we, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rf_waddr", mg_rf_waddr, mon_e.waddr);
          chk("rf_wdata", mg_rf_wdata, mon_e.wd_m);
          chk("rf_wstrb", mg_rf_wstrb, mon_e.ws_m);
          chk("sb_rf_waddr", sb_rf_waddr, mon_e.waddr);
          chk("sb_rf_wdata", sb_rf_wdata, mon_e.wd_s);
          chk("sb_rf_wstrb", sb_rf_wstrb, mon_e.ws_s);
        end
      end
    end
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    resetn = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, LT_LW, '0, '0, '0, 2'b00, '0, 1'b0);
    model_clear();
    #1 resetn = 1'b0;
    #1 check_zero("reset");
    do_reset();

    // LB at a=3 sign-extends 0x80
    drive(1, 1, 6'd5, 1, LT_LB, 32'h3, 32'h80AA_BBCC, 32'h0, 2'b00, 64'h0, 0);
    step(); set_idle(); #1;
    chk("lb_we", mg_rf_we, 1);
    chk("lb_wdata", mg_rf_wdata, 32'hFFFF_FF80);
    chk("lb_wstrb", mg_rf_wstrb, 4'hF);
    chk("lb_sb_wstrb", sb_rf_wstrb, 4'hF);
    step();
    chk("lb_cnt", mg_retire_cnt, 1);
    chk("lb_we_pulse", mg_rf_we, 0);

    // LWL a=1 in both modes
    drive(1, 1, 6'd7, 1, LT_LWL, 32'h1, 32'h1122_3344, 32'hAAAA_AAAA, 2'b00, 64'h0, 0);
    step(); set_idle(); #1;
    chk("lwl_m_wdata", mg_rf_wdata, 32'h3344_AAAA);
    chk("lwl_m_wstrb", mg_rf_wstrb, 4'hF);
    chk("lwl_s_wdata", sb_rf_wdata, 32'h3344_0000);
    chk("lwl_s_wstrb", sb_rf_wstrb, 4'b1100);
    step();

    // MULT then MTLO
    drive(1, 0, 6'd0, 0, LT_LW, 32'h0, 32'h0, 32'h0, 2'b01, 64'h0000_0001_FFFF_FFFE, 0);
    step(); set_idle(); step();
    chk("mult_hi", mg_hi, 32'h1);
    chk("mult_lo", mg_lo, 32'hFFFF_FFFE);
    drive(1, 0, 6'd0, 0, LT_LW, 32'h5, 32'h0, 32'h0, 2'b11, 64'h0, 0);
    step(); set_idle(); step();
    chk("mtlo_lo", mg_lo, 32'h5);
    chk("mtlo_hi", mg_hi, 32'h1);

    // Three stalled cycles, then exactly one commit
    drive(1, 1, 6'd9, 1, LT_LW, 32'h0, 32'hDEAD_BEEF, 32'h0, 2'b00, 64'h0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      ms_valid = 1'b0; wb_stall = 1'b1; #1;
      chk("stall_allowin", mg_ws_allowin, 0);
      chk("stall_we", mg_rf_we, 0);
      step();
    end
    wb_stall = 1'b0; #1;
    chk("release_we", mg_rf_we, 1);
    chk("release_wdata", mg_rf_wdata, 32'hDEAD_BEEF);
    step();
    chk("release_cnt", mg_retire_cnt, 5);
    chk("release_we_once", mg_rf_we, 0);

    // Exception drains without side effects
    drive(1, 1, 6'd3, 0, LT_LW, 32'h77, 32'h0, 32'h0, 2'b01, 64'h1234_5678_9ABC_DEF0, 1);
    step(); set_idle(); #1;
    chk("excp_we", mg_rf_we, 0);
    chk("excp_valid", mg_ws_valid, 1);
    step();
    chk("excp_drained", mg_ws_valid, 0);
    chk("excp_hi", mg_hi, 32'h1);
    chk("excp_lo", mg_lo, 32'h5);
    chk("excp_cnt", mg_retire_cnt, 5);

    // 17 back-to-back commits wrap the 4-bit counter to 1
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1, 1, 6'(i), 0, LT_LW, 32'(i + 1), 32'h0, 32'h0, 2'b10, 64'h0, 0);
      step();
    end
    set_idle(); step();
    chk("wrap_sb_cnt", sb_retire_cnt, 4'd1);
    chk("wrap_cnt", mg_retire_cnt, 17);
    chk("wrap_hi", mg_hi, 32'd17);

    // Reset asserted while an instruction is held by a stall
    drive(1, 1, 6'd12, 1, LT_LW, 32'h0, 32'hCAFE_F00D, 32'h0, 2'b00, 64'h0, 0);
    step();
    ms_valid = 1'b0; wb_stall = 1'b1;
    step();
    #1 resetn = 1'b0;
    #1 check_zero("midstall");
    model_clear();
    wb_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (3) step();
    chk("midstall_no_commit", mg_retire_cnt, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 6'($urandom), $urandom_range(0, 1) != 0,
            3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)),
            {$urandom, $urandom}, $urandom_range(0, 7) == 0);
      wb_stall = ($urandom_range(0, 3) == 0);
      step();
    end
    set_idle();
    repeat (3) step();
    chk("drain_queue", 64'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
